// File: rtl/opacc_pkg.sv
// opacc_pkg: shared types and constants for the outer-product accumulator.
package opacc_pkg;

  localparam int OPACC_NREGS   = 4;   // number of C tiles
  localparam int OPACC_VL      = 4;   // columns per tile (b vector width)
  localparam int OPACC_ML      = 4;   // rows per tile (a vector width)
  localparam int OPACC_XLEN    = 64;  // element width
  localparam int OPACC_MUL_LAT = 2;   // accept-to-writeback stages

  localparam int OPACC_ADDR_W  = (OPACC_NREGS > 1) ? $clog2(OPACC_NREGS) : 1;
  localparam int OPACC_ROW_W   = (OPACC_ML > 1) ? $clog2(OPACC_ML) : 1;

  typedef enum logic [1:0] {
    OPACC_ACC = 2'b00,
    OPACC_SUB = 2'b01,
    OPACC_OVW = 2'b10,
    OPACC_CLR = 2'b11
  } opacc_mode_e;

  typedef logic [OPACC_XLEN-1:0]   opacc_elem_t;
  typedef opacc_elem_t [OPACC_VL-1:0] opacc_row_t;
  typedef opacc_row_t  [OPACC_ML-1:0] opacc_tile_t;

  typedef struct packed {
    logic                    valid;
    logic [OPACC_ADDR_W-1:0] addr;
    opacc_mode_e             mode;
    opacc_tile_t             products;
  } opacc_stage_t;

  // One bit per encodable row index: set where the row physically exists.
  function automatic logic [(1 << OPACC_ROW_W)-1:0] opacc_row_mask();
    logic [(1 << OPACC_ROW_W)-1:0] m;
    m = '0;
    for (int r = 0; r < (1 << OPACC_ROW_W); r++) begin
      m[r] = (r < OPACC_ML);
    end
    return m;
  endfunction

  // Element update for one tile cell; add/sub wrap modulo 2^XLEN.
  function automatic opacc_elem_t opacc_apply(input opacc_mode_e mode,
                                              input opacc_elem_t old_val,
                                              input opacc_elem_t prod);
    opacc_elem_t res;
    case (mode)
      OPACC_ACC: res = old_val + prod;
      OPACC_SUB: res = old_val - prod;
      OPACC_OVW: res = prod;
      OPACC_CLR: res = '0;
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/opacc_if.sv
// opacc_if: op, load and read channels of the outer-product accumulator.
interface opacc_if;
  import opacc_pkg::*;

  // outer-product op channel
  logic                           ab_valid;
  logic                           ab_ready;
  logic [OPACC_ADDR_W-1:0]        ab_addr;
  logic [1:0]                     ab_mode;
  logic [OPACC_ML*OPACC_XLEN-1:0] ai;
  logic [OPACC_VL*OPACC_XLEN-1:0] bi;

  // row load channel
  logic                           ld_valid;
  logic                           ld_ready;
  logic [OPACC_ADDR_W-1:0]        ld_addr;
  logic [OPACC_ROW_W-1:0]         ld_row;
  logic [OPACC_VL*OPACC_XLEN-1:0] ld_data;

  // row read channel
  logic                           rd_valid;
  logic                           rd_ready;
  logic [OPACC_ADDR_W-1:0]        rd_addr;
  logic [OPACC_ROW_W-1:0]         rd_row;
  logic                           rdata_valid;
  logic [OPACC_VL*OPACC_XLEN-1:0] rdata;

  logic                           busy;

  modport master (
    output ab_valid, ab_addr, ab_mode, ai, bi,
    output ld_valid, ld_addr, ld_row, ld_data,
    output rd_valid, rd_addr, rd_row,
    input  ab_ready, ld_ready, rd_ready, rdata_valid, rdata, busy
  );

  modport slave (
    input  ab_valid, ab_addr, ab_mode, ai, bi,
    input  ld_valid, ld_addr, ld_row, ld_data,
    input  rd_valid, rd_addr, rd_row,
    output ab_ready, ld_ready, rd_ready, rdata_valid, rdata, busy
  );

endinterface

// File: rtl/opacc_mul_array.sv
// opacc_mul_array: ML x VL multiplier array followed by a MUL_LAT-deep
// register chain carrying valid/addr/mode alongside the products. The chain
// after the multipliers gives retiming room to spread the partial products.
module opacc_mul_array
  import opacc_pkg::*;
#(
  parameter int MUL_LAT = OPACC_MUL_LAT
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  input  logic [OPACC_ADDR_W-1:0]        i_addr,
  input  opacc_mode_e                    i_mode,
  input  logic [OPACC_ML*OPACC_XLEN-1:0] i_ai,
  input  logic [OPACC_VL*OPACC_XLEN-1:0] i_bi,
  output opacc_stage_t                   o_final,
  output logic [MUL_LAT-1:0]             o_valid,
  output logic [MUL_LAT-1:0][OPACC_ADDR_W-1:0] o_addr
);

  opacc_stage_t                r_stages [MUL_LAT];
  opacc_stage_t                w_entry;

  // Form the low-XLEN products a[i]*b[j] and the sideband of the new op.
  always_comb begin
    w_entry       = '0;
    w_entry.valid = i_valid;
    w_entry.addr  = i_addr;
    w_entry.mode  = i_mode;
    for (int i = 0; i < OPACC_ML; i++) begin
      for (int j = 0; j < OPACC_VL; j++) begin
        w_entry.products[i][j] = i_ai[i*OPACC_XLEN +: OPACC_XLEN]
                               * i_bi[j*OPACC_XLEN +: OPACC_XLEN];
      end
    end
  end

  // Advance the pipeline every cycle; reset only drops the valids.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < MUL_LAT; k++) begin
        r_stages[k].valid <= 1'b0;
      end
    end else begin
      r_stages[0] <= w_entry;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_stages[k] <= r_stages[k-1];
      end
    end
  end

  // Expose per-stage valid/addr for the hazard scoreboard.
  always_comb begin
    o_valid = '0;
    o_addr  = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      o_valid[k] = r_stages[k].valid;
      o_addr[k]  = r_stages[k].addr;
    end
  end

  assign o_final = r_stages[MUL_LAT-1];

endmodule

// File: rtl/opacc_pipe.sv
// opacc_pipe: multi-tile outer-product accumulator with random-access row
// load/read ports and a hazard scoreboard guarding tiles with ops in flight.
module opacc_pipe
  import opacc_pkg::*;
#(
  parameter int MUL_LAT = OPACC_MUL_LAT
) (
  input  logic    i_clk,
  input  logic    i_reset,
  opacc_if.slave  bus
);

  localparam logic [(1 << OPACC_ROW_W)-1:0] ROW_OK = opacc_row_mask();

  opacc_tile_t                          r_tile [OPACC_NREGS];
  logic                                 r_rdata_valid;
  opacc_row_t                           r_rdata;

  opacc_stage_t                         w_wb;
  logic [MUL_LAT-1:0]                   w_valid;
  logic [MUL_LAT-1:0][OPACC_ADDR_W-1:0] w_addr;
  opacc_tile_t                          w_wb_tile;

  logic w_ab_ready, w_ab_fire;
  logic w_ld_ready, w_ld_fire, w_ld_hit;
  logic w_rd_ready, w_rd_fire, w_rd_pipe_hit;
  logic w_busy;

  opacc_mul_array #(
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (w_ab_fire),
    .i_addr  (bus.ab_addr),
    .i_mode  (opacc_mode_e'(bus.ab_mode)),
    .i_ai    (bus.ai),
    .i_bi    (bus.bi),
    .o_final (w_wb),
    .o_valid (w_valid),
    .o_addr  (w_addr)
  );

  // Hazard scoreboard: block loads/reads to tiles with ops in flight; a
  // same-cycle op beats a load, and a same-row load beats a read.
  always_comb begin
    w_ab_ready    = ~i_reset;
    w_ab_fire     = bus.ab_valid & w_ab_ready;
    w_busy        = 1'b0;
    w_ld_hit      = bus.ab_valid & (bus.ab_addr == bus.ld_addr);
    w_rd_pipe_hit = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      w_busy        = w_busy | w_valid[k];
      w_ld_hit      = w_ld_hit | (w_valid[k] & (w_addr[k] == bus.ld_addr));
      w_rd_pipe_hit = w_rd_pipe_hit | (w_valid[k] & (w_addr[k] == bus.rd_addr));
    end
    w_ld_ready = ~i_reset & ~w_ld_hit;
    w_ld_fire  = bus.ld_valid & w_ld_ready;
    w_rd_ready = ~i_reset & ~w_rd_pipe_hit
               & ~(w_ab_fire & (bus.ab_addr == bus.rd_addr))
               & ~(w_ld_fire & (bus.ld_addr == bus.rd_addr) & (bus.ld_row == bus.rd_row));
    w_rd_fire  = bus.rd_valid & w_rd_ready;
  end

  // Final stage: read the target tile (already holding any previous
  // writeback) and apply the op mode to every element.
  always_comb begin
    w_wb_tile = '0;
    for (int i = 0; i < OPACC_ML; i++) begin
      for (int j = 0; j < OPACC_VL; j++) begin
        w_wb_tile[i][j] = opacc_apply(w_wb.mode, r_tile[w_wb.addr][i][j],
                                      w_wb.products[i][j]);
      end
    end
  end

  // Tile storage: whole-tile writeback and single-row load; the scoreboard
  // guarantees they never target the same tile in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int n = 0; n < OPACC_NREGS; n++) begin
        r_tile[n] <= '0;
      end
    end else begin
      if (w_wb.valid) begin
        r_tile[w_wb.addr] <= w_wb_tile;
      end
      if (w_ld_fire && ROW_OK[bus.ld_row]) begin
        r_tile[bus.ld_addr][bus.ld_row] <= bus.ld_data;
      end
    end
  end

  // Registered read port; rdata holds between accepted reads.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_rdata_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rdata <= ROW_OK[bus.rd_row] ? r_tile[bus.rd_addr][bus.rd_row] : '0;
      end
    end
  end

  assign bus.ab_ready    = w_ab_ready;
  assign bus.ld_ready    = w_ld_ready;
  assign bus.rd_ready    = w_rd_ready;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.rdata       = r_rdata;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_opacc_pipe.sv
// tb_opacc_pipe: directed stimulus, a queue-based reference model checked
// every cycle, and literal expectations for the hand-computed scenarios.
module tb_opacc_pipe;
  import opacc_pkg::*;

  localparam int MUL_LAT = 2;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;
  int   cyc      = 0;

  opacc_if bus();

  opacc_pipe #(.MUL_LAT(MUL_LAT)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [1:0]  addr;
    logic [1:0]  mode;
    logic [255:0] a;
    logic [255:0] b;
  } op_t;

  op_t          pend[$];
  logic [63:0]  m_tile [4][4][4];
  logic         m_rdv   = 1'b0;
  logic [255:0] m_rdata = '0;

  function automatic logic [255:0] v4(input logic [63:0] e0, input logic [63:0] e1,
                                      input logic [63:0] e2, input logic [63:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic bit pend_on(input logic [1:0] t);
    foreach (pend[k]) if (pend[k].addr == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void exp_readies(output logic ea, output logic el, output logic er);
    logic ab_f, ld_f;
    ea   = !reset;
    ab_f = bus.ab_valid && ea;
    el   = !reset && !pend_on(bus.ld_addr) && !(bus.ab_valid && bus.ab_addr == bus.ld_addr);
    ld_f = bus.ld_valid && el;
    er   = !reset && !pend_on(bus.rd_addr) && !(ab_f && bus.ab_addr == bus.rd_addr)
           && !(ld_f && bus.ld_addr == bus.rd_addr && bus.ld_row == bus.rd_row);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at every edge, using pre-edge inputs.
  always @(posedge clk) begin
    logic ea, el, er;
    logic [63:0] p;
    cyc++;
    if (reset) begin
      chk_en = 1'b1;
      pend.delete();
      m_rdv   = 1'b0;
      m_rdata = '0;
      for (int n = 0; n < 4; n++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) m_tile[n][i][j] = 64'd0;
    end else begin
      exp_readies(ea, el, er);
      m_rdv = bus.rd_valid && er;
      if (m_rdv)
        for (int j = 0; j < 4; j++) m_rdata[j*64 +: 64] = m_tile[bus.rd_addr][bus.rd_row][j];
      while (pend.size() > 0 && pend[0].due == cyc) begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            p = pend[0].a[i*64 +: 64] * pend[0].b[j*64 +: 64];
            case (pend[0].mode)
              2'b00:   m_tile[pend[0].addr][i][j] = m_tile[pend[0].addr][i][j] + p;
              2'b01:   m_tile[pend[0].addr][i][j] = m_tile[pend[0].addr][i][j] - p;
              2'b10:   m_tile[pend[0].addr][i][j] = p;
              default: m_tile[pend[0].addr][i][j] = 64'd0;
            endcase
          end
        void'(pend.pop_front());
      end
      if (bus.ld_valid && el)
        for (int j = 0; j < 4; j++) m_tile[bus.ld_addr][bus.ld_row][j] = bus.ld_data[j*64 +: 64];
      if (bus.ab_valid && ea)
        pend.push_back('{cyc + MUL_LAT, bus.ab_addr, bus.ab_mode, bus.ai, bus.bi});
    end
  end

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic ea, el, er;
    if (chk_en) begin
      exp_readies(ea, el, er);
      chk1("ab_ready", bus.ab_ready, ea);
      chk1("ld_ready", bus.ld_ready, el);
      chk1("rd_ready", bus.rd_ready, er);
      chk1("busy", bus.busy, pend.size() != 0);
      chk1("rdata_valid", bus.rdata_valid, m_rdv);
      chkv("rdata", bus.rdata, m_rdata);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic ab_op(input logic [1:0] addr, input logic [1:0] mode,
                       input logic [255:0] a, input logic [255:0] b);
    bus.ab_addr = addr; bus.ab_mode = mode; bus.ai = a; bus.bi = b;
    bus.ab_valid = 1'b1;
    @(posedge clk); #1;
    bus.ab_valid = 1'b0;
  endtask

  task automatic load_row(input logic [1:0] addr, input logic [1:0] row, input logic [255:0] d);
    bit ok;
    ok = 1'b0;
    bus.ld_addr = addr; bus.ld_row = row; bus.ld_data = d; bus.ld_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ld_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    chk1("ld_accept", ok, 1'b1);
  endtask

  task automatic read_row(input logic [1:0] addr, input logic [1:0] row, output logic [255:0] d);
    bit ok;
    ok = 1'b0;
    bus.rd_addr = addr; bus.rd_row = row; bus.rd_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    chk1("rd_accept", ok, 1'b1);
    @(negedge clk);
    chk1("rd_latency", bus.rdata_valid, 1'b1);
    d = bus.rdata;
    @(posedge clk); #1;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] d;
    int busy_cnt, blk_ld, blk_rd;
    bit ok;
    reset = 1'b1;
    bus.ab_valid = 1'b0; bus.ab_addr = 2'd0; bus.ab_mode = 2'b00; bus.ai = '0; bus.bi = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = 2'd0; bus.ld_row = 2'd0; bus.ld_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = 2'd0; bus.rd_row = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("reset_ab_ready", bus.ab_ready, 1'b0);
    chk1("reset_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state read
    read_row(2'd2, 2'd3, d);
    chkv("reset_tile2_row3", d, 256'd0);

    // load + acc
    load_row(2'd0, 2'd1, v4(64'd1, 64'd2, 64'd3, 64'd4));
    ab_op(2'd0, OPACC_ACC, v4(64'd0, 64'd5, 64'd0, 64'd0), v4(64'd1, 64'd1, 64'd1, 64'd1));
    read_row(2'd0, 2'd1, d);
    chkv("acc_row1", d, v4(64'd6, 64'd7, 64'd8, 64'd9));

    // three back-to-back ops on tile 1; busy window
    bus.ab_addr = 2'd1; bus.ab_mode = OPACC_ACC;
    bus.ai = v4(64'd2, 64'd2, 64'd2, 64'd2); bus.bi = v4(64'd3, 64'd3, 64'd3, 64'd3);
    bus.ab_valid = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (k == 2) bus.ab_valid = 1'b0;
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    @(posedge clk); #1;
    chki("busy_cycles", busy_cnt, MUL_LAT + 2);
    read_row(2'd1, 2'd0, d);
    chkv("b2b_row0", d, v4(64'd18, 64'd18, 64'd18, 64'd18));
    read_row(2'd1, 2'd3, d);
    chkv("b2b_row3", d, v4(64'd18, 64'd18, 64'd18, 64'd18));

    // hazard window on tile 3, load to tile 2 in the same window
    bus.ab_addr = 2'd3; bus.ab_mode = OPACC_ACC;
    bus.ai = v4(64'd1, 64'd1, 64'd1, 64'd1); bus.bi = v4(64'd1, 64'd1, 64'd1, 64'd1);
    bus.ab_valid = 1'b1;
    bus.ld_addr = 2'd2; bus.ld_row = 2'd0; bus.ld_data = v4(64'd11, 64'd12, 64'd13, 64'd14);
    bus.ld_valid = 1'b1;
    @(negedge clk);
    chk1("hz_ld_other_tile", bus.ld_ready, 1'b1);
    @(posedge clk); #1;
    bus.ab_valid = 1'b0;
    bus.ld_addr = 2'd3; bus.ld_row = 2'd0; bus.ld_data = v4(64'd100, 64'd101, 64'd102, 64'd103);
    bus.rd_addr = 2'd3; bus.rd_row = 2'd1; bus.rd_valid = 1'b1;
    blk_ld = 0; blk_rd = 0; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.ld_ready) blk_ld++;
      if (!bus.rd_ready) blk_rd++;
      if (bus.ld_ready && bus.rd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.rd_valid = 1'b0;
    chk1("hz_accept", ok, 1'b1);
    chki("hz_ld_blocked", blk_ld, MUL_LAT);
    chki("hz_rd_blocked", blk_rd, MUL_LAT);
    @(negedge clk);
    chk1("hz_rdata_valid", bus.rdata_valid, 1'b1);
    chkv("hz_rd_data", bus.rdata, v4(64'd1, 64'd1, 64'd1, 64'd1));
    @(posedge clk); #1;
    read_row(2'd3, 2'd0, d);
    chkv("hz_load_t3", d, v4(64'd100, 64'd101, 64'd102, 64'd103));
    read_row(2'd2, 2'd0, d);
    chkv("hz_load_t2", d, v4(64'd11, 64'd12, 64'd13, 64'd14));

    // wrap, sub, ovw, clr on tile 0 row 2
    load_row(2'd0, 2'd2, v4(ONES, ONES, ONES, ONES));
    ab_op(2'd0, OPACC_ACC, v4(64'd0, 64'd0, 64'd1, 64'd0), v4(64'd1, 64'd1, 64'd1, 64'd1));
    read_row(2'd0, 2'd2, d);
    chkv("wrap_acc", d, 256'd0);
    ab_op(2'd0, OPACC_SUB, v4(64'd0, 64'd0, 64'd1, 64'd0), v4(64'd1, 64'd1, 64'd1, 64'd1));
    read_row(2'd0, 2'd2, d);
    chkv("wrap_sub", d, v4(ONES, ONES, ONES, ONES));
    ab_op(2'd0, OPACC_OVW, v4(64'd7, 64'd7, 64'd7, 64'd7), v4(64'd6, 64'd6, 64'd6, 64'd6));
    read_row(2'd0, 2'd2, d);
    chkv("ovw", d, v4(64'd42, 64'd42, 64'd42, 64'd42));
    ab_op(2'd0, OPACC_CLR, v4(64'd9, 64'd9, 64'd9, 64'd9), v4(64'd9, 64'd9, 64'd9, 64'd9));
    read_row(2'd0, 2'd2, d);
    chkv("clr", d, 256'd0);

    // reset with two ops in flight and a read request pending
    ab_op(2'd1, OPACC_OVW, v4(64'd3, 64'd3, 64'd3, 64'd3), v4(64'd4, 64'd4, 64'd4, 64'd4));
    ab_op(2'd2, OPACC_ACC, v4(64'd5, 64'd5, 64'd5, 64'd5), v4(64'd5, 64'd5, 64'd5, 64'd5));
    reset = 1'b1;
    bus.rd_addr = 2'd0; bus.rd_row = 2'd0; bus.rd_valid = 1'b1;
    @(negedge clk);
    chk1("rst_rd_ready", bus.rd_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.rd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk1("post_rst_busy", bus.busy, 1'b0);
    chk1("post_rst_no_rdv", bus.rdata_valid, 1'b0);
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++)
      for (int r = 0; r < 4; r++) begin
        read_row(2'(n), 2'(r), d);
        chkv("post_rst_zero", d, 256'd0);
      end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d checks failed", n_fail, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
